// File: rtl/eco32f_dm_cache.sv
// ---------------------------------------------------------------------------
// eco32f_dm_cache
//
// Direct-mapped cache array used as the eco32f data cache. The line is
// selected by the virtual read address and the tag is compared against
// the TLB-translated physical address. Data, tag and valid are read
// synchronously, one cycle after read_addr_i is presented. The hit/miss flag
// is combinational against match_addr_i. Refills and store hits go through a
// single one-word-per-cycle write port.
//
// Parameters:
//   OPTION_CACHE_BLOCK_WIDTH  log2 of the line size in bytes (default 5 = 32 B)
//   OPTION_CACHE_SET_WIDTH    log2 of the number of lines (default 8 = 256)
//
// Ports:
//   clk_i         clock; all state updates on the rising edge
//   rst_ni        asynchronous active-low reset
//   miss_o        1 = sampled line is invalid or its tag differs from match_addr_i
//   read_addr_i   virtual read/index address, sampled every clock
//   match_addr_i  physical address used for the tag compare (combinational)
//   read_data_o   word at the read_addr_i sampled on the previous edge
//   write_addr_i  physical byte address of the word to write
//   write_data_i  word to write
//   write_en_i    write strobe for one word
//   invalidate_i  clear all valid bits
//
// Configuration macro:
//   ECO32F_CACHE_WRITE_FIRST_EN
//     Defined   : a write at the same edge as the read sample is forwarded
//                 to the read (write-first).
//     Undefined : read-first. The read returns the pre-write contents.
// ---------------------------------------------------------------------------
module eco32f_dm_cache #(
    parameter int OPTION_CACHE_BLOCK_WIDTH = 5,
    parameter int OPTION_CACHE_SET_WIDTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        miss_o,
    input  logic [31:0] read_addr_i,
    input  logic [31:0] match_addr_i,
    output logic [31:0] read_data_o,
    input  logic [31:0] write_addr_i,
    input  logic [31:0] write_data_i,
    input  logic        write_en_i,
    input  logic        invalidate_i
);

    localparam int B      = OPTION_CACHE_BLOCK_WIDTH;
    localparam int S      = OPTION_CACHE_SET_WIDTH;
    localparam int WORD_W = B - 2;
    localparam int TAG_W  = 32 - B - S;
    localparam int LOC_W  = S + WORD_W;
    localparam int LINES  = 1 << S;
    localparam int DEPTH  = 1 << LOC_W;

    // Storage. The data and tag RAMs are never reset. The valid vector
    // gates every hit, so stale RAM contents after reset are harmless.
    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;

    // Registered read results, all captured from read_addr_i at the same edge.
    logic [31:0]      data_q;
    logic [31:0]      data_d;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_d;
    logic             v_q;
    logic             v_d;

    // Address field decode.
    logic [S-1:0]      rd_idx;
    logic [WORD_W-1:0] rd_word;
    logic [LOC_W-1:0]  rd_loc;
    logic [S-1:0]      wr_idx;
    logic [WORD_W-1:0] wr_word;
    logic [LOC_W-1:0]  wr_loc;
    logic [TAG_W-1:0]  wr_tag;
    logic [TAG_W-1:0]  match_tag;

    assign rd_idx    = read_addr_i[B+S-1:B];
    assign rd_word   = read_addr_i[B-1:2];
    assign rd_loc    = read_addr_i[B+S-1:2];
    assign wr_idx    = write_addr_i[B+S-1:B];
    assign wr_word   = write_addr_i[B-1:2];
    assign wr_loc    = write_addr_i[B+S-1:2];
    assign wr_tag    = write_addr_i[31:B+S];
    assign match_tag = match_addr_i[31:B+S];

    // Byte-offset bits and the parts of each address that are not used for
    // that address's role are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{read_addr_i[1:0], read_addr_i[31:B+S],
                                write_addr_i[1:0], match_addr_i[B+S-1:0]};

    // Valid next state. Invalidate wins over a simultaneous write, so the
    // write's valid set is dropped. Its data and tag still land.
    always_comb begin
        valid_d = valid_q;
        if (invalidate_i) begin
            valid_d = '0;
        end else if (write_en_i) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Read capture. By default these are the pre-write array contents
    // (read-first). With write-first enabled, a same-edge write to the
    // sampled line is forwarded. The tag and valid are forwarded when the
    // index matches. The data is forwarded only when the word also matches.
    always_comb begin
        data_d = data_mem[rd_loc];
        tag_d  = tag_mem[rd_idx];
        v_d    = valid_q[rd_idx];
`ifdef ECO32F_CACHE_WRITE_FIRST_EN
        if (write_en_i && (wr_idx == rd_idx)) begin
            tag_d = wr_tag;
            v_d   = ~invalidate_i;
            if (wr_word == rd_word) begin
                data_d = write_data_i;
            end
        end
`endif
    end

    // Valid flags and the captured valid bit are the only reset state. The
    // captured valid reset to 0 forces miss_o high until the first real read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            v_q     <= 1'b0;
        end else begin
            valid_q <= valid_d;
            v_q     <= v_d;
        end
    end

    // RAM arrays and their output registers. There is no reset, so these
    // map onto plain synchronous RAM with a registered read port.
    always_ff @(posedge clk_i) begin
        if (write_en_i) begin
            data_mem[wr_loc] <= write_data_i;
            tag_mem[wr_idx]  <= wr_tag;
        end
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign read_data_o = data_q;
    assign miss_o      = ~v_q | (tag_q != match_tag);

endmodule

// File: tb/tb_eco32f_dm_cache.sv
// ---------------------------------------------------------------------------
// tb_eco32f_dm_cache
//
// Testbench for eco32f_dm_cache at default parameters (32 B lines, 256 lines).
// A reference model keeps the cache contents as plain arrays indexed by line
// and by word. It predicts each cycle's read from the contents as they are
// before that edge's write and invalidate. Directed steps walk the basic use
// cases first. A randomized phase then mixes reads, writes and invalidates
// over a small set of tags and indices, including the last line.
// ---------------------------------------------------------------------------
module tb_eco32f_dm_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss;
    logic [31:0] read_addr;
    logic [31:0] match_addr;
    logic [31:0] read_data;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        write_en;
    logic        invalidate;

    int total = 0;
    int bad   = 0;

    // Reference model state, in byte-address terms.
    logic [31:0] mData  [2048];
    bit          mKnown [2048];
    logic [18:0] mTag   [256];
    bit          mValid [256];

    // Prediction for the read sampled at the most recent edge.
    bit          expValid;
    logic [18:0] expTag;
    logic [31:0] expWord;
    bit          expKnown;

    eco32f_dm_cache dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .miss_o       (miss),
        .read_addr_i  (read_addr),
        .match_addr_i (match_addr),
        .read_data_o  (read_data),
        .write_addr_i (write_addr),
        .write_data_i (write_data),
        .write_en_i   (write_en),
        .invalidate_i (invalidate)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] idxOf(input logic [31:0] a);
        return a[12:5];
    endfunction

    function automatic logic [10:0] locOf(input logic [31:0] a);
        return a[12:2];
    endfunction

    function automatic logic [18:0] tagOf(input logic [31:0] a);
        return a[31:13];
    endfunction

    function automatic logic [31:0] mkAddr(input logic [18:0] t, input logic [7:0] i,
                                           input logic [2:0] w);
        return {t, i, w, 2'b00};
    endfunction

    // Drive one cycle from a falling edge. Predict the read from the model,
    // then apply the write and invalidate to the model at the rising edge.
    // Return on the next falling edge with the strobes cleared.
    task automatic applyStimulus(input logic [31:0] ra, input logic [31:0] ma,
                                 input logic [31:0] wa, input logic [31:0] wd,
                                 input logic we, input logic inv);
        read_addr  = ra;
        match_addr = ma;
        write_addr = wa;
        write_data = wd;
        write_en   = we;
        invalidate = inv;
        expValid = mValid[idxOf(ra)];
        expTag   = mTag[idxOf(ra)];
        expWord  = mData[locOf(ra)];
        expKnown = mKnown[locOf(ra)];
`ifdef ECO32F_CACHE_WRITE_FIRST_EN
        if (we && idxOf(wa) == idxOf(ra)) begin
            expTag   = tagOf(wa);
            expValid = !inv;
            if (locOf(wa) == locOf(ra)) begin
                expWord  = wd;
                expKnown = 1'b1;
            end
        end
`endif
        @(posedge clk);
        if (we) begin
            mData[locOf(wa)]  = wd;
            mKnown[locOf(wa)] = 1'b1;
            mTag[idxOf(wa)]   = tagOf(wa);
        end
        if (inv) begin
            foreach (mValid[i]) mValid[i] = 1'b0;
        end else if (we) begin
            mValid[idxOf(wa)] = 1'b1;
        end
        @(negedge clk);
        write_en   = 1'b0;
        invalidate = 1'b0;
    endtask

    // Compare the DUT against the model prediction for the current cycle.
    task automatic checkOutput(input string name);
        logic expMiss;
        expMiss = !expValid || (expTag != tagOf(match_addr));
        total++;
        assert (miss === expMiss) else begin
            bad++;
            $error("[TB] FAIL %s miss: observed=%0b expected=%0b", name, miss, expMiss);
        end
        if (expKnown) begin
            total++;
            assert (read_data === expWord) else begin
                bad++;
                $error("[TB] FAIL %s data: observed=%08h expected=%08h", name, read_data, expWord);
            end
        end
    endtask

    // Compare one observed value against a fixed expectation.
    task automatic checkValue(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", name, obs, exp);
        end
    endtask

    initial begin
        logic [18:0] tagSet [3];
        logic [7:0]  idxSet [4];
        logic [31:0] ra;
        logic [31:0] ma;
        logic [31:0] wa;
        logic [18:0] t;
        logic [7:0]  ix;

        tagSet[0] = 19'h00000;
        tagSet[1] = 19'h00001;
        tagSet[2] = 19'h7FFFF;
        idxSet[0] = 8'h00;
        idxSet[1] = 8'h01;
        idxSet[2] = 8'h80;
        idxSet[3] = 8'hFF;
        foreach (mData[i]) begin
            mData[i]  = '0;
            mKnown[i] = 1'b0;
        end
        foreach (mTag[i]) begin
            mTag[i]   = '0;
            mValid[i] = 1'b0;
        end

        rst_n      = 1'b0;
        read_addr  = '0;
        match_addr = '0;
        write_addr = '0;
        write_data = '0;
        write_en   = 1'b0;
        invalidate = 1'b0;
        repeat (3) @(negedge clk);
        checkValue("reset miss", {31'b0, miss}, 32'd1);
        rst_n = 1'b1;

        $display("[TB] step 1: cold read misses");
        applyStimulus(32'h00001000, 32'h00001000, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s1");
        checkValue("s1 miss", {31'b0, miss}, 32'd1);

        $display("[TB] step 2: refill line 0x1000 and read word 2");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h00001000, 32'h00001000, 32'h00001000 + 32'(i * 4),
                          32'hA0 + 32'(i), 1'b1, 1'b0);
        end
        applyStimulus(32'h00001008, 32'h00001008, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s2");
        checkValue("s2 miss", {31'b0, miss}, 32'd0);
        checkValue("s2 data", read_data, 32'hA2);

        $display("[TB] step 3: same index, different tag");
        applyStimulus(32'h00001008, 32'h00003008, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s3");
        checkValue("s3 miss", {31'b0, miss}, 32'd1);

        $display("[TB] step 4: store hit");
        applyStimulus(32'h00001004, 32'h00001004, 32'h00001004, 32'hDEADBEEF, 1'b1, 1'b0);
        checkOutput("s4 write");
        applyStimulus(32'h00001004, 32'h00001004, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s4 read");
        checkValue("s4 data", read_data, 32'hDEADBEEF);
        checkValue("s4 miss", {31'b0, miss}, 32'd0);
        applyStimulus(32'h00001000, 32'h00001000, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s4 word0");
        checkValue("s4 word0 data", read_data, 32'hA0);

        $display("[TB] step 5: invalidate");
        applyStimulus(32'h00001000, 32'h00001000, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("s5 inv");
        applyStimulus(32'h00001000, 32'h00001000, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s5 after inv");
        checkValue("s5 miss", {31'b0, miss}, 32'd1);
        applyStimulus(32'h00000000, 32'h00000000, 32'h00002000, 32'h00000055, 1'b1, 1'b1);
        checkOutput("s5 inv+write");
        applyStimulus(32'h00002000, 32'h00002000, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s5 read 2000");
        checkValue("s5 inv+write miss", {31'b0, miss}, 32'd1);
        checkValue("s5 inv+write data", read_data, 32'h00000055);

        $display("[TB] step 6: read during write");
        applyStimulus(32'h00001010, 32'h00001010, 32'h00001010, 32'h12345678, 1'b1, 1'b0);
        checkOutput("s6 same cycle");
`ifdef ECO32F_CACHE_WRITE_FIRST_EN
        checkValue("s6 same cycle data", read_data, 32'h12345678);
`else
        checkValue("s6 same cycle data", read_data, 32'h000000A4);
`endif
        applyStimulus(32'h00001010, 32'h00001010, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("s6 next");
        checkValue("s6 next data", read_data, 32'h12345678);

        $display("[TB] boundary: last line and unrelated writes");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'hFFFFFFE0, 32'hFFFFFFE0, 32'hFFFFFFE0 + 32'(i * 4),
                          32'hF0F0_0000 + 32'(i), 1'b1, 1'b0);
        end
        applyStimulus(32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("last line");
        checkValue("last line miss", {31'b0, miss}, 32'd0);
        checkValue("last line data", read_data, 32'hF0F00007);
        applyStimulus(32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000020, 32'h0BADF00D, 1'b1, 1'b0);
        checkOutput("other idx write");
        checkValue("other idx miss", {31'b0, miss}, 32'd0);
        checkValue("other idx data", read_data, 32'hF0F00007);

        $display("[TB] randomized phase");
        for (int n = 0; n < 400; n++) begin
            t  = tagSet[$urandom_range(0, 2)];
            ix = ($urandom_range(0, 4) == 4) ? 8'($urandom) : idxSet[$urandom_range(0, 3)];
            ra = mkAddr(t, ix, 3'($urandom));
            ma = ($urandom_range(0, 3) != 0) ? ra : mkAddr(tagSet[$urandom_range(0, 2)], ix, 3'b0);
            wa = mkAddr(tagSet[$urandom_range(0, 2)],
                        ($urandom_range(0, 1) == 1) ? ix : idxSet[$urandom_range(0, 3)],
                        3'($urandom));
            applyStimulus(ra, ma, wa, $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 31) == 0));
            checkOutput("random");
        end

        $display("[TB] asynchronous reset clears a hit");
        applyStimulus(32'h00000040, 32'h00000040, 32'h00000040, 32'h00000007, 1'b1, 1'b0);
        applyStimulus(32'h00000040, 32'h00000040, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("pre reset hit");
        rst_n = 1'b0;
        #2;
        checkValue("async reset miss", {31'b0, miss}, 32'd1);
        foreach (mValid[i]) mValid[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
